// File: rtl/skew_buffer_array.sv
// skew_buffer_array: per-lane delay lines that skew an aligned word into a
// systolic wavefront (mode 0, lane i late by i) or deskew a wavefront back
// into aligned words (mode 1, lane i late by N-1-i).
// Optional build macro: SKEW_ZERO_FILL_EN forces data_out[i] to 0 while its
// valid is low; without it the tap register contents are shown as-is.
module skew_buffer_array #(
   parameter int unsigned N  = 8,
   parameter int unsigned DW = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mode,
   input  logic                   in_valid,
   input  logic [N-1:0][DW-1:0]   data_in,
   input  logic                   stall,
   input  logic                   flush,
   output logic                   in_ready,
   output logic [N-1:0][DW-1:0]   data_out,
   output logic [N-1:0]           out_valid,
   output logic                   busy,
   output logic                   drain_done
);

   localparam int unsigned IW = $clog2(N);

   // Per lane, stage 0 is the LSB slot of the chain.
   logic [N-1:0][N-1:0]          vld_q;
   logic [N-1:0][N-1:0][DW-1:0]  dat_q;
   logic                         mode_q;
   logic                         busy_q;
   logic                         adv;
   logic                         accept;
   logic [N-1:0][IW-1:0]         tap;

   assign adv      = !stall;
   assign accept   = in_valid && adv && !flush;
   assign in_ready = !stall;

   // Tap selection per lane and busy over the live part of each chain.
   always_comb begin
      tap  = '0;
      busy = 1'b0;
      for (int i = 0; i < N; i++) begin
         tap[i] = mode_q ? IW'(N - 1 - i) : IW'(i);
         for (int k = 0; k < N; k++) begin
            if (k <= int'(tap[i])) busy = busy | vld_q[i][k];
         end
      end
   end

   // Output taps come straight from registers; no input-to-output path.
   always_comb begin
      data_out  = '0;
      out_valid = '0;
      for (int i = 0; i < N; i++) begin
         out_valid[i] = vld_q[i][tap[i]];
`ifdef SKEW_ZERO_FILL_EN
         data_out[i]  = vld_q[i][tap[i]] ? dat_q[i][tap[i]] : '0;
`else
         data_out[i]  = dat_q[i][tap[i]];
`endif
      end
   end

   assign drain_done = busy_q && !busy;

   // Delay-line shift, flush of valids, idle-only mode capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         dat_q  <= '0;
         mode_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         // Flush wins over stall and drops a same-cycle beat.
         if (flush) begin
            vld_q <= '0;
         end else if (adv) begin
            for (int i = 0; i < N; i++) begin
               vld_q[i] <= {vld_q[i][N-2:0], accept};
            end
         end
         // Data registers keep their contents across a flush.
         if (adv && !flush) begin
            for (int i = 0; i < N; i++) begin
               dat_q[i] <= {dat_q[i][N-2:0], data_in[i]};
            end
         end
         // Mode only changes with nothing in flight, so a wavefront never
         // gets re-tapped mid-flight.
         if (adv && !busy) mode_q <= mode;
         busy_q <= busy;
      end
   end

endmodule

// File: tb/tb_skew_buffer_array.sv
// Directed bench for skew_buffer_array at N=4, DW=8.
module tb_skew_buffer_array;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 mode;
   logic                 in_valid;
   logic [N-1:0][DW-1:0] data_in;
   logic                 stall;
   logic                 flush;
   logic                 in_ready;
   logic [N-1:0][DW-1:0] data_out;
   logic [N-1:0]         out_valid;
   logic                 busy;
   logic                 drain_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   skew_buffer_array #(
      .N  (N),
      .DW (DW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .in_valid   (in_valid),
      .data_in    (data_in),
      .stall      (stall),
      .flush      (flush),
      .in_ready   (in_ready),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .busy       (busy),
      .drain_done (drain_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Move to just after the next rising edge, i.e. the start of a cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Settle, then compare the per-cycle status outputs.
   task automatic obs(input string tag, input logic [3:0] ov, input logic b, input logic dd);
      #2;
      check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
      check({tag, " busy"}, 32'(busy), 32'(b));
      check({tag, " drain_done"}, 32'(drain_done), 32'(dd));
   endtask

   task automatic lane(input string tag, input int i, input logic [7:0] exp);
      check($sformatf("%s lane%0d", tag, i), 32'(data_out[i[1:0]]), 32'(exp));
   endtask

   function automatic logic [31:0] word(input logic [7:0] base);
      return {base + 8'd3, base + 8'd2, base + 8'd1, base};
   endfunction

   // Single skew beat 0x13..0x10 accepted in the current cycle.
   task automatic run_skew(input string tag);
      string t;
      mode     = 1'b0;
      in_valid = 1'b1;
      data_in  = word(8'h10);
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         t = $sformatf("%s c%0d", tag, c);
         obs(t, (c <= 4) ? 4'(1 << (c - 1)) : 4'b0, c <= 4, c == 5);
         if (c <= 4) lane(t, c - 1, 8'h10 + 8'(c - 1));
         tick();
      end
   endtask

   initial begin
      string t;
      int    ln;
      int    la;
      int    lb;
      logic [3:0] ev;

      rst_n    = 1'b0;
      mode     = 1'b0;
      in_valid = 1'b0;
      data_in  = '0;
      stall    = 1'b0;
      flush    = 1'b0;

      // Reset state.
      #2;
      check("rst out_valid", 32'(out_valid), 32'h0);
      check("rst data_out", 32'(data_out), 32'h0);
      check("rst busy", 32'(busy), 32'h0);
      check("rst drain_done", 32'(drain_done), 32'h0);
      check("rst in_ready", 32'(in_ready), 32'h1);
      stall = 1'b1;
      #1;
      check("rst in_ready stall", 32'(in_ready), 32'h0);
      stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1. Skew.
      run_skew("t1");

      // 2. Deskew, back-to-back beats A then B.
      mode     = 1'b1;
      in_valid = 1'b1;
      data_in  = word(8'hA0);
      tick();
      data_in  = word(8'hB0);
      for (int c = 1; c <= 6; c++) begin
         if (c == 2) in_valid = 1'b0;
         la = 4 - c;
         lb = 5 - c;
         ev = 4'b0;
         if (la >= 0 && la <= 3) ev[la[1:0]] = 1'b1;
         if (lb >= 0 && lb <= 3) ev[lb[1:0]] = 1'b1;
         t = $sformatf("t2 c%0d", c);
         obs(t, ev, c <= 5, c == 6);
         if (la >= 0 && la <= 3) lane({t, " A"}, la, 8'hA0 + 8'(la));
         if (lb >= 0 && lb <= 3) lane({t, " B"}, lb, 8'hB0 + 8'(lb));
         tick();
      end

      // 3. Stall in cycles 2-3.
      mode     = 1'b0;
      in_valid = 1'b1;
      data_in  = word(8'h10);
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         stall = (c == 2) || (c == 3);
         ln = (c == 1) ? 0 : (c <= 4) ? 1 : (c == 5) ? 2 : (c == 6) ? 3 : -1;
         t = $sformatf("t3 c%0d", c);
         obs(t, (ln >= 0) ? 4'(1 << ln) : 4'b0, c <= 6, c == 7);
         check({t, " in_ready"}, 32'(in_ready), 32'(!stall));
         if (ln >= 0) lane(t, ln, 8'h10 + 8'(ln));
         tick();
      end
      stall = 1'b0;

      // 4. Flush in cycle 2 with a competing input beat.
      in_valid = 1'b1;
      data_in  = word(8'h10);
      tick();
      in_valid = 1'b0;
      obs("t4 c1", 4'b0001, 1'b1, 1'b0);
      tick();
      flush    = 1'b1;
      in_valid = 1'b1;
      data_in  = word(8'hE0);
      obs("t4 c2", 4'b0010, 1'b1, 1'b0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      for (int c = 3; c <= 7; c++) begin
         t = $sformatf("t4 c%0d", c);
         obs(t, 4'b0, 1'b0, c == 3);
`ifdef SKEW_ZERO_FILL_EN
         check({t, " zero fill"}, 32'(data_out), 32'h0);
`endif
         tick();
      end

      // 5. Mode lock: switch to deskew mid-flight, then a deskew beat at cycle 6.
      mode     = 1'b0;
      in_valid = 1'b1;
      data_in  = word(8'h10);
      tick();
      mode = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         in_valid = (c == 6);
         if (c == 6) data_in = word(8'hC0);
         t = $sformatf("t5 c%0d", c);
         if (c <= 4) begin
            obs(t, 4'(1 << (c - 1)), 1'b1, 1'b0);
            lane(t, c - 1, 8'h10 + 8'(c - 1));
         end else if (c >= 7 && c <= 10) begin
            obs(t, 4'(1 << (10 - c)), 1'b1, 1'b0);
            lane(t, 10 - c, 8'hC0 + 8'(10 - c));
         end else begin
            obs(t, 4'b0, 1'b0, (c == 5) || (c == 11));
         end
         tick();
      end

      // 6. Asynchronous reset mid-cycle 2 of a skew beat.
      mode     = 1'b0;
      in_valid = 1'b1;
      data_in  = word(8'h10);
      tick();
      in_valid = 1'b0;
      obs("t6 c1", 4'b0001, 1'b1, 1'b0);
      tick();
      obs("t6 c2", 4'b0010, 1'b1, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6 async out_valid", 32'(out_valid), 32'h0);
      check("t6 async data_out", 32'(data_out), 32'h0);
      check("t6 async busy", 32'(busy), 32'h0);
      check("t6 async drain_done", 32'(drain_done), 32'h0);
      @(posedge clk);
      #4;
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         obs($sformatf("t6 post c%0d", c), 4'b0, 1'b0, 1'b0);
         tick();
      end
      run_skew("t6 again");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/skew_buffer_array.md
Name: skew_buffer_array

Overview:
- Parametrised successor to the fixed-skew systolic input array.
- Per-lane delay lines skew a parallel SRAM word into a systolic-array wavefront (lane i late by i cycles), or deskew an array's output wavefront back into aligned words (lane i late by N-1-i cycles).
- Adds configurable data width, a runtime mode, per-lane valid tracking, stall, flush and drain status.
- Sits between SRAM read ports and the PE array edge, on both the operand-feed and result-collect sides.

Parameters:
N, 8, number of lanes (>=2)
DW, 8, data width per lane in bits

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
mode  in  1  0 = skew, 1 = deskew; captured only while idle
in_valid  in  1  input word valid
data_in  in  N x DW  input word, lane i = data_in[i]
stall  in  1  freeze all state
flush  in  1  synchronous discard of all in-flight beats
in_ready  out  1  = !stall
data_out  out  N x DW  per-lane output, lane i = data_out[i]
out_valid  out  N  per-lane output valid
busy  out  1  any in-flight beat not yet emitted
drain_done  out  1  one-cycle pulse when busy falls

Behaviour:
- adv = !stall. A beat is accepted when in_valid & adv & !flush.
- Storage per lane: a chain of N stages s[0..N-1], each holding {valid, data}.
  - On adv: s[0] <= {accepted, data_in[i]} and s[k] <= s[k-1].
  - On stall: all stages and mode_r hold.
- Tap per lane: d_i = i when mode_r = 0; d_i = N-1-i when mode_r = 1.
- Outputs: data_out[i] = s[d_i].data and out_valid[i] = s[d_i].valid. Latency of lane i = 1 + d_i cycles; outputs are registered, with no combinational input-to-output path.
- busy = OR over lanes of s[k].valid for k = 0..d_i. Valid bits beyond a lane's tap are ignored.
- drain_done = busy_q & !busy, where busy_q is busy registered. It pulses for exactly one cycle, including after a flush.
- Mode lock:
  - mode_r <= mode on every edge where busy = 0 and adv = 1.
  - While busy = 1, mode_r holds; mode changes are ignored until the pipeline drains.
  - A beat accepted in the idle cycle that loads mode_r uses the newly loaded mode.
- Flush:
  - All valid bits clear on the next edge; data registers keep their contents.
  - Flush overrides stall and drops a same-cycle input beat.
  - mode_r follows the idle rule from the next cycle onward.
- Back-to-back beats on consecutive cycles are supported at one beat per cycle, with no bubbles.
- Reset (asynchronous, any time, including mid-operation):
  - All valid bits, data, mode_r and busy_q = 0.
  - Outputs after reset: data_out = 0, out_valid = 0, busy = 0, drain_done = 0, in_ready = !stall.

Optional Feature:
- Macro SKEW_ZERO_FILL_EN.
- Defined: data_out[i] is forced to 0 whenever out_valid[i] = 0. This supplies the zero padding the PE array needs at wavefront edges.
- Undefined: data_out[i] shows the tap register contents regardless of valid (stale data visible), which saves N*DW AND gates.
- Valid, busy and timing behaviour are identical in both builds.

Test Plan:
All tests use N=4, DW=8, with beat accepted at cycle 0.
1. Skew: mode=0, single beat data_in = {0x13,0x12,0x11,0x10} (lane3..lane0).
   - Lane0 0x10 valid in cycle 1, lane1 0x11 in cycle 2, lane2 0x12 in cycle 3, lane3 0x13 in cycle 4.
   - busy = 1 in cycles 1-4; drain_done = 1 in cycle 5 only.
2. Deskew: mode=1, same beat.
   - Lane3 in cycle 1, lane2 in cycle 2, lane1 in cycle 3, lane0 in cycle 4.
   - Back-to-back beats 0xA0.. and 0xB0.. on cycles 0-1 emerge on consecutive cycles per lane.
3. Stall: skew beat at cycle 0, stall = 1 in cycles 2-3.
   - Outputs hold cycle-2 values during the stall; in_ready = 0.
   - Lane3 emits 0x13 in cycle 6; busy stays 1 through cycle 6.
4. Flush: skew beat at cycle 0, flush = 1 in cycle 2 together with in_valid = 1.
   - From cycle 3: out_valid = 0 and busy = 0; drain_done = 1 in cycle 3.
   - The flush-cycle beat never appears.
   - With SKEW_ZERO_FILL_EN defined, data_out = 0 from cycle 3.
5. Mode lock: skew beat at cycle 0, mode switched to 1 in cycle 1.
   - Beat still exits with skew timing.
   - A deskew beat accepted at cycle 6 (idle) exits with deskew timing.
6. Reset: drop rst_n asynchronously mid-cycle 2 of a skew beat.
   - Outputs go to 0 immediately, without waiting for a clock edge.
   - After release, no stale valid appears; a new beat behaves as in test 1.
